// File: rtl/dual_lane_merge_pkg.sv
// Shared constants and helpers for the dual-lane merge block: lane ids,
// pointer-width calculation and a saturating counter increment.
package dual_lane_merge_pkg;

    localparam logic LANE1 = 1'b0;
    localparam logic LANE2 = 1'b1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 32'sd1;
        end
        return r;
    endfunction

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_v;
        max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        if (value >= max_v) begin
            return max_v;
        end else begin
            return value + 32'd1;
        end
    endfunction

endpackage

// File: rtl/dual_lane_merge_if.sv
// Bus bundle for dual_lane_merge: two gated input lanes, the merged
// ready/valid output stream and the per-lane drop counters.
interface dual_lane_merge_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             ct1;
    logic [WIDTH-1:0] in1;
    logic             ct2;
    logic [WIDTH-1:0] in2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_lane;
    logic [CNT_W-1:0] ovf1;
    logic [CNT_W-1:0] ovf2;

    // The merge block drives the output stream.
    modport master (
        input  ct1, in1, ct2, in2, out_ready,
        output out_valid, out_data, out_lane, ovf1, ovf2
    );

    // The surrounding lane registers and the downstream consumer.
    modport slave (
        output ct1, in1, ct2, in2, out_ready,
        input  out_valid, out_data, out_lane, ovf1, ovf2
    );
endinterface

// File: rtl/dual_lane_merge_lane_fifo.sv
// Per-lane FIFO. A push into a full FIFO is accepted only when the same
// FIFO is popped in that cycle; otherwise it is dropped and flagged.
module lane_fifo
    import dual_lane_merge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             full,
    output logic             drop
);
    localparam int PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;
    logic             wr_en_s;
    logic             rd_en_s;

    // Status flags and write/read enables from registered occupancy.
    always_comb begin
        empty   = (count_r == {(PTR_W+1){1'b0}});
        full    = (count_r == (PTR_W+1)'(DEPTH));
        wr_en_s = push && (!full || pop);
        rd_en_s = pop && !empty;
        drop    = push && full && !pop;
        head    = mem_r[rd_ptr_r];
    end

    // Storage: when full with a pop, the write slot is the slot being read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {(PTR_W+1){1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + (PTR_W+1)'(1);
                2'b01:   count_r <= count_r - (PTR_W+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/dual_lane_merge.sv
// Merges two gated lanes (ct low = valid data) through per-lane FIFOs onto
// one round-robin ready/valid stream. Drop counters are built only when
// DUAL_LANE_MERGE_OVF_CNT_EN is defined; otherwise ovf1/ovf2 read 0.
module dual_lane_merge
    import dual_lane_merge_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dual_lane_merge_if.master bus
);
    logic [WIDTH-1:0] head1_s, head2_s;
    logic             empty1_s, empty2_s;
    logic             full1_s, full2_s;
    logic             drop1_s, drop2_s;
    logic             pop1_s, pop2_s;
    logic             load_s, any_s, sel_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_lane_r;
    logic             last_r;

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (!bus.ct1),
        .push_data (bus.in1),
        .pop       (pop1_s),
        .head      (head1_s),
        .empty     (empty1_s),
        .full      (full1_s),
        .drop      (drop1_s)
    );

    lane_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (!bus.ct2),
        .push_data (bus.in2),
        .pop       (pop2_s),
        .head      (head2_s),
        .empty     (empty2_s),
        .full      (full2_s),
        .drop      (drop2_s)
    );

    // Round-robin choice between non-empty FIFOs and the matching pop.
    always_comb begin
        any_s  = !empty1_s || !empty2_s;
        load_s = !out_valid_r || bus.out_ready;
        if (!empty1_s && !empty2_s) begin
            sel_s = ~last_r;
        end else if (!empty1_s) begin
            sel_s = LANE1;
        end else begin
            sel_s = LANE2;
        end
        pop1_s = load_s && !empty1_s && (sel_s == LANE1);
        pop2_s = load_s && !empty2_s && (sel_s == LANE2);
    end

    // Output register; last_r starts at LANE2 so lane 1 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_lane_r  <= LANE1;
            last_r      <= LANE2;
        end else if (load_s && any_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= (sel_s == LANE2) ? head2_s : head1_s;
            out_lane_r  <= sel_s;
            last_r      <= sel_s;
        end else if (load_s) begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_lane_r  <= out_lane_r;
            last_r      <= last_r;
        end else begin
            out_valid_r <= out_valid_r;
            out_data_r  <= out_data_r;
            out_lane_r  <= out_lane_r;
            last_r      <= last_r;
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_lane  = out_lane_r;

`ifdef DUAL_LANE_MERGE_OVF_CNT_EN
    logic [CNT_W-1:0] ovf1_r, ovf2_r;
    logic             unused_full_s;

    assign unused_full_s = full1_s | full2_s;

    // Saturating per-lane drop counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf1_r <= {CNT_W{1'b0}};
            ovf2_r <= {CNT_W{1'b0}};
        end else begin
            if (drop1_s) begin
                ovf1_r <= CNT_W'(sat_inc(32'(ovf1_r), CNT_W));
            end else begin
                ovf1_r <= ovf1_r;
            end
            if (drop2_s) begin
                ovf2_r <= CNT_W'(sat_inc(32'(ovf2_r), CNT_W));
            end else begin
                ovf2_r <= ovf2_r;
            end
        end
    end

    assign bus.ovf1 = ovf1_r;
    assign bus.ovf2 = ovf2_r;
`else
    logic unused_drop_s;

    assign unused_drop_s = drop1_s | drop2_s | full1_s | full2_s;
    assign bus.ovf1      = {CNT_W{1'b0}};
    assign bus.ovf2      = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/dual_lane_merge.md
Name: dual_lane_merge

Overview:
- Consumer end of the gated-lane interface. Upstream lane registers drive a lane's data to 0 in any cycle where that lane's control bit (ct) is high, and pass data through when it is low.
- This block receives two such lanes. It treats ct low as "valid data", buffers each lane in its own FIFO, and merges both lanes round-robin onto one ready/valid output stream tagged with the source lane.
- Sits directly downstream of the paired lane registers, replacing ad-hoc "+1" consumers.

Parameters:
- WIDTH, 8: lane and output data width.
- DEPTH, 4: entries per lane FIFO; power of two, at least 2.
- CNT_W, 8: width of the overflow counters.

Ports:
- clk, input, 1: single clock; all state updates on posedge.
- rst_n, input, 1: asynchronous active-low reset.
- ct1, input, 1: lane 1 control; high = lane blanked, no data this cycle.
- in1, input, WIDTH: lane 1 data; sampled only when ct1 is low.
- ct2, input, 1: lane 2 control; same meaning as ct1.
- in2, input, WIDTH: lane 2 data; same meaning as in1.
- out_valid, output, 1: out_data and out_lane are valid.
- out_ready, input, 1: downstream accepts the word.
- out_data, output, WIDTH: merged data word.
- out_lane, output, 1: source of out_data; 0 = lane 1, 1 = lane 2.
- ovf1, output, CNT_W: lane 1 dropped-word count.
- ovf2, output, CNT_W: lane 2 dropped-word count.

Behaviour:
- Reset (async, rst_n low): FIFOs empty; out_valid = 0; out_data = 0; out_lane = 0; ovf1 = ovf2 = 0; round-robin pointer selects lane 1 first.
- Capture:
  - At each posedge with cti low, ini is pushed into FIFO i.
  - ct high means nothing is pushed; the value on ini is ignored, never stored.
- Full FIFO:
  - A push to a full FIFO is dropped, unless the same FIFO is popped in the same cycle. In that case the push succeeds and the count is unchanged.
  - A dropped push increments ovfi, saturating at all-ones.
- Output stage: one register (out_valid, out_data, out_lane).
  - It loads when it is empty or when out_valid and out_ready are both high (transfer).
  - Load source is the head of a non-empty FIFO, chosen by the arbiter; the chosen FIFO pops in that cycle.
- Arbiter:
  - If only one FIFO is non-empty, it is chosen.
  - If both are non-empty, the lane not most recently served is chosen.
  - The pointer updates only on a load.
- Latency: a word captured at edge N appears on out_valid/out_data after edge N+1 at the earliest (2-cycle latency). This holds for an empty path and a free output stage.
- Throughput: one word per cycle sustained.
- Hold rule: while out_valid is high and out_ready is low, out_data and out_lane hold stable. Capture into the FIFOs continues during this time.
- Ordering: per-lane order is preserved. There is no ordering guarantee across lanes beyond round-robin alternation.
- FIFO empty detection uses registered state, so there is no combinational path from in*/ct* to out_*.
- out_ready may toggle freely. out_valid never drops without a transfer.
- Reset mid-operation: all buffered and in-flight words are discarded immediately.

Optional Feature:
- Macro: DUAL_LANE_MERGE_OVF_CNT_EN
- Defined: ovf1/ovf2 count drops as described above.
- Undefined: counter logic is not built; ovf1/ovf2 are tied to 0. Drops still occur, silently. Ports remain present in both builds.

Decomposition:
- Package dual_lane_merge_pkg holds:
  - lane id constants LANE1 = 0, LANE2 = 1;
  - a pointer-width constant function clog2(DEPTH);
  - the saturating-increment helper.
- Sub-module lane_fifo (WIDTH, DEPTH):
  - Ports: push, push_data, pop, head, empty, full, drop.
  - Implements the push-on-full-with-pop rule.
  - Instantiated twice, once per lane.
- The arbiter and output register live in the top.

Test Plan:
- Single word: ct1=0, in1=0x5A for one cycle, out_ready=1 -> out_valid=1, out_data=0x5A, out_lane=0 after the 2nd edge; out_valid low the next cycle.
- Blanking: ct1=ct2=1 for 10 cycles with in1=0xFF, in2=0xEE -> out_valid never asserts; ovf1 = ovf2 = 0.
- Round-robin: both lanes push 3 words each on the same cycles (lane 1 0x11,0x12,0x13; lane 2 0x21,0x22,0x23), out_ready=1 -> output order 0x11,0x21,0x12,0x22,0x13,0x23 with lanes alternating 0,1.
- Backpressure and overflow: out_ready=0, lane 1 pushes 8 words with DEPTH=4 -> output holds the first word stable. FIFO holds words 2..5 and words 6..8 are dropped, so ovf1=3 (macro defined) or 0 (undefined). Raising out_ready yields words 1..5 in order.
- Full with simultaneous pop: FIFO 1 full and output draining, push every cycle -> no drops, ovf1 stays 0, continuous stream.
- Async reset mid-stream: assert rst_n=0 between edges with words in flight -> out_valid drops immediately and all counters read 0; after release, the next push appears with 2-cycle latency.
